// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divisor helper
// used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin; both flops reset to RST_VAL
// so an idle-high line does not look like a start edge coming out of reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with a start-aligned baud counter, mid-bit sampling
// and a valid/ready holding register with frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV  = baud_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic            rxs;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            cnt_half;
  logic            cnt_full;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  assign cnt_half = (cnt == CW'(HALF - 1));
  assign cnt_full = (cnt == CW'(DIV - 1));
  assign busy     = (state != IDLE);

  // The counter restarts on the start edge so every sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt_half) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt_full) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt_full) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              // A byte landing on the handshake cycle replaces the accepted one.
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HI: begin
          if (rxs)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=10: ideal frames, back-to-back bytes, glitch,
// framing error with break, overrun and mid-frame reset.
module tb_uart_rx;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int fe_cnt = 0, fe_cyc = -1;
  int ov_cnt = 0, ov_cyc = -1;
  int vr_cnt = 0, vr_cyc = -1;
  logic prev_valid = 1'b0;

  uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid && !prev_valid) begin vr_cnt++; vr_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (overrun) begin ov_cnt++; ov_cyc = cyc; end
    prev_valid = rx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input int i);
    if (got_q.size() > i) return {24'd0, got_q[i]};
    return 32'hxxxx_xxxx;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop, output int c0);
    c0 = cyc;
    rx = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(DIV);
    end
    rx = stop;
    step(DIV);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2;
    logic [7:0] b;

    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    step(3);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    step(5);

    // Single ideal frame 0xA5
    send_byte(8'hA5, 1'b1, c0);
    step(5);
    check("a5_count", got_q.size(), 1);
    check("a5_data", qat(0), 32'hA5);
    check("a5_latency", vr_cyc - c0, 98);
    check("a5_ferr", fe_cnt, 0);

    // Back-to-back frames
    got_q.delete();
    send_byte(8'h00, 1'b1, c0);
    send_byte(8'hFF, 1'b1, c0);
    send_byte(8'h55, 1'b1, c0);
    send_byte(8'h80, 1'b1, c0);
    step(5);
    check("b2b_count", got_q.size(), 4);
    check("b2b_0", qat(0), 32'h00);
    check("b2b_1", qat(1), 32'hFF);
    check("b2b_2", qat(2), 32'h55);
    check("b2b_3", qat(3), 32'h80);
    check("b2b_ferr", fe_cnt, 0);
    check("b2b_ovr", ov_cnt, 0);

    // Three-clock glitch: false start
    step(10);
    got_q.delete();
    c0 = cyc;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(1);
    check("glitch_busy_hi", busy, 1);
    step(4);
    check("glitch_busy_lo", busy, 0);
    step(100);
    check("glitch_novalid", got_q.size(), 0);

    // Framing error followed by a held-low break
    send_byte(8'h3C, 1'b0, c0);
    step(30);
    check("fe_count", fe_cnt, 1);
    check("fe_time", fe_cyc - c0, 98);
    check("fe_wait_busy", busy, 1);
    check("fe_novalid", got_q.size(), 0);
    rx = 1'b1;
    step(10);
    check("fe_idle", busy, 0);
    send_byte(8'h12, 1'b1, c0);
    step(5);
    check("fe_next_count", got_q.size(), 1);
    check("fe_next_data", qat(0), 32'h12);
    check("fe_count_after", fe_cnt, 1);

    // Overrun with consumer stalled
    got_q.delete();
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1, c1);
    send_byte(8'h22, 1'b1, c2);
    step(3);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 32'h11);
    check("ovr_count", ov_cnt, 1);
    check("ovr_time", ov_cyc - c2, 98);
    check("ovr_nohs", got_q.size(), 0);
    rx_ready = 1'b1;
    step(1);
    check("ovr_hs_drop", rx_valid, 0);
    check("ovr_hs_data", qat(0), 32'h11);
    check("ovr_hs_count", got_q.size(), 1);

    // Reset during data bit 4 of 0xC3
    step(10);
    got_q.delete();
    b = 8'hC3;
    rx = 1'b0;
    step(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      step(DIV);
    end
    rx = b[4];
    step(5);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    rx = 1'b1;
    step(1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_valid", rx_valid, 0);
    step(3);
    rst_n = 1'b1;
    step(20);
    check("mid_post_valid", rx_valid, 0);
    check("mid_post_nobyte", got_q.size(), 0);
    send_byte(8'h7E, 1'b1, c0);
    step(5);
    check("mid_7e_count", got_q.size(), 1);
    check("mid_7e_data", qat(0), 32'h7E);
    check("final_ovr", ov_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
